// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide issue controller.
package md_pkg;

   // Op encoding shared with the MD unit's MDOp input.
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MBUSY = 2'd1,
      DBUSY = 2'd2
   } md_state_e;

   localparam int CNT_W = 5;

   // mult/multu/div/divu: ops that occupy the unit for several cycles.
   function automatic logic is_multdiv(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd4);
   endfunction

   function automatic logic is_mult(input logic [2:0] op);
      return (op == 3'd1) || (op == 3'd2);
   endfunction

   // Any op the MD unit actually executes (excludes none and reserved).
   function automatic logic is_issuable(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd6);
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Loadable down-counter tracking remaining busy cycles of a mult/div.
module md_busy_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   // Load has priority; otherwise count down on request.
   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (dec)
         count_d = count_q - W'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/occupancy controller between E-stage and the HI/LO multiply-divide unit.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   input  logic        d_uses_md,
   output logic [2:0]  md_op,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_we,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        proto_err
);

   localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);

   md_state_e        state_q, state_d;
   logic [2:0]       md_op_q, md_op_d;
   logic [31:0]      md_a_q, md_a_d;
   logic [31:0]      md_b_q, md_b_d;
   logic             md_we_q, md_we_d;
   logic             done_q, done_d;
   logic             proto_err_q, proto_err_d;

   logic             idle;
   logic             live_req;
   logic             accept;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_init;
   logic [CNT_W-1:0] cnt_value;

   assign idle     = (state_q == IDLE);
   assign live_req = req_valid & ~flush;
   assign accept   = live_req & idle & is_issuable(req_op);

   // Only mult/div occupy the unit; mthi/mtlo are single-cycle writes.
   assign cnt_load = accept & is_multdiv(req_op);
   assign cnt_init = is_mult(req_op) ? MULT_INIT : DIV_INIT;
   assign cnt_dec  = ~idle & ~cnt_zero;

   md_busy_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_init),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .zero     (cnt_zero)
   );

   // Next-state, issue register and sticky protocol error.
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      md_op_d     = MD_NONE;
      md_we_d     = 1'b0;
      md_a_d      = md_a_q;
      md_b_d      = md_b_q;
      // A request landing while the unit is occupied means the stall failed.
      proto_err_d = proto_err_q | (live_req & ~idle & is_issuable(req_op));

      if (accept) begin
         md_op_d = req_op;
         md_a_d  = req_a;
         md_b_d  = req_b;
         md_we_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (cnt_load)
               state_d = is_mult(req_op) ? MBUSY : DBUSY;
         end
         MBUSY, DBUSY: begin
            // Flush never cancels an in-flight op, so expiry is unconditional.
            if (cnt_zero) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         md_op_q     <= MD_NONE;
         md_a_q      <= '0;
         md_b_q      <= '0;
         md_we_q     <= 1'b0;
         done_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         md_op_q     <= md_op_d;
         md_a_q      <= md_a_d;
         md_b_q      <= md_b_d;
         md_we_q     <= md_we_d;
         done_q      <= done_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Stall covers the accept cycle of a mult/div plus every busy cycle.
   assign stall = d_uses_md & (~idle | (live_req & is_multdiv(req_op) & idle));

   assign busy      = ~idle;
   assign md_op     = md_op_q;
   assign md_a      = md_a_q;
   assign md_b      = md_b_q;
   assign md_we     = md_we_q;
   assign done      = done_q;
   assign proto_err = proto_err_q;

   // Counter value is consumed only through its zero flag.
   logic unused_cnt;
   assign unused_cnt = ^cnt_value;

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and occupancy controller between the E-stage decode/operand path and the HI/LO multiply-divide unit.
- Accepts one MD request per cycle from E and forwards a registered op, operands and write-enable to the MD unit.
- Models mult/div latency with a countdown, drives the pipeline stall for D-stage instructions that touch HI/LO, and suppresses issue on exception/eret flush.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal range 1..31)
- DIV_LAT, 10, busy cycles for div/divu (legal range 1..31)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  E-stage holds an MD instruction this cycle
- req_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- flush  in  1  exception/eret taken at M; kills the E-stage request this cycle
- d_uses_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_op  out  3  op driven to MD unit (registered)
- md_a  out  32  registered operand A
- md_b  out  32  registered operand B
- md_we  out  1  one-cycle HI/LO write strobe to MD unit
- busy  out  1  mult/div in flight
- stall  out  1  stall request to D stage
- done  out  1  one-cycle pulse when a mult/div completes
- proto_err  out  1  sticky: request arrived while busy

Behaviour:
- Reset: state IDLE, count 0. md_op=0, md_a=0, md_b=0, md_we=0, busy=0, done=0, proto_err=0.
- Accept condition: req_valid & ~flush & state==IDLE & req_op in 1..6. Op 0 and op 7 are never accepted; they cause no error.
- Flush: blocks acceptance only in its own cycle. An already-issued op is never cancelled.
- Issue timing: on accept at cycle T, md_op/md_a/md_b are loaded and md_we=1 for exactly cycle T+1. In every other cycle md_we=0 and md_op=0; md_a and md_b hold their last values.
- States and transitions:
  - IDLE: on accept of op 1/2, go to MBUSY with count=MULT_LAT-1. On op 3/4, go to DBUSY with count=DIV_LAT-1. On op 5/6, stay in IDLE (single-cycle write, no busy).
  - MBUSY/DBUSY: busy=1. Decrement count each cycle. When count==0, return to IDLE on the next edge with done=1 for that one cycle.
  - busy is therefore high for exactly LAT cycles, T+1..T+LAT. done=1 at T+LAT+1.
- Back-to-back: a new request is acceptable in the cycle done=1 (state is IDLE). An mthi issued right after done overwrites the unit's result normally.
- Request while busy: not accepted, no issue, proto_err set to 1 and held until reset. The pipeline must prevent this via stall.
- stall (combinational) = d_uses_md & (busy | (req_valid & ~flush & req_op in 1..4 & state==IDLE)).
  - Consequence: stall is high from the accept cycle until the last busy cycle.
- Reset mid-operation: returns to IDLE within one cycle. No done pulse, no md_we.
- Simultaneous flush and count expiry: completion proceeds normally; done still pulses.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_NONE..MD_MTLO (3-bit), matching the MD unit's MDOp encoding
  - state enum IDLE/MBUSY/DBUSY
  - helper functions is_multdiv(op) and is_mult(op)
- Optional sub-module md_busy_counter: 5-bit loadable down-counter with zero flag. Everything else stays flat.

Test Plan:
- mult accepted at T, a=7, b=-3 → md_we=1, md_op=1, md_a=7, md_b=0xFFFFFFFD at T+1; busy high T+1..T+5; done at T+6; proto_err=0.
- divu at T with d_uses_md=1 throughout → stall high T..T+10; busy T+1..T+10; done T+11; stall low at T+11.
- mthi a=0x12345678 at T → md_we=1, md_op=5 at T+1; busy, stall and done all remain 0.
- req_valid=1 op=div with flush=1 at T → no md_we at T+1, busy stays 0; same request without flush at T+1 → md_we=1 at T+2.
- mult at T, second mult presented at T+2 → second not issued; proto_err=1 from T+3 and held; first op completes with done at T+6.
- div at T, reset at T+4 → busy=0, md_we=0, done=0 from T+5; no done pulse ever appears for that div.
